// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a read-only fetch port and a read/write data port share one
// memory with a fixed read latency. One access in flight, round-robin on ties, registered outputs.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_writeAddr,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_writeEn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;  // 1: data port was granted most recently
  logic                gnt_d_q, gnt_d_d;    // 1: access in flight belongs to data port
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic                pick_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    gnt_d_d    = gnt_d_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    maddr_d    = '0;
    waddr_d    = '0;
    wdata_d    = '0;
    wen_d      = 1'b0;
    // On a tie the port that did not win last time goes first
    pick_d     = d_req & (~if_req | ~last_d_q);

    unique case (state_q)
      ST_IDLE: begin
        if (if_req | d_req) begin
          state_d  = ST_ISSUE;
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          we_d     = pick_d & d_we;
          maddr_d  = pick_d ? d_addr : if_addr;
          if (pick_d & d_we) begin
            waddr_d = d_addr;
            wdata_d = d_wdata;
            wen_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
          d_ack_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(READ_LAT - 1);
          maddr_d = maddr_q;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (gnt_d_q) begin
            d_rdata_d = mem_dataOut;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_dataOut;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          maddr_d = maddr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_d_q   <= 1'b1;
      gnt_d_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      maddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      gnt_d_q    <= gnt_d_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      maddr_q    <= maddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
    end
  end

  assign if_ack        = if_ack_q;
  assign if_rdata      = if_rdata_q;
  assign d_ack         = d_ack_q;
  assign d_rdata       = d_rdata_q;
  assign mem_addr      = maddr_q;
  assign mem_writeAddr = waddr_q;
  assign mem_writeData = wdata_q;
  assign mem_writeEn   = wen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (READ_LAT 1 and 3), each with a behavioural memory,
// checked cycle by cycle against a transaction-level model of grant order, timing and data.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NDUT   = 2;

  logic clk = 1'b0;
  logic reset;

  logic [NDUT-1:0]   if_req, if_ack, d_req, d_we, d_ack, mem_we;
  logic [ADDR_W-1:0] if_addr   [NDUT];
  logic [ADDR_W-1:0] d_addr    [NDUT];
  logic [DATA_W-1:0] d_wdata   [NDUT];
  logic [DATA_W-1:0] if_rdata  [NDUT];
  logic [DATA_W-1:0] d_rdata   [NDUT];
  logic [ADDR_W-1:0] mem_addr  [NDUT];
  logic [ADDR_W-1:0] mem_waddr [NDUT];
  logic [DATA_W-1:0] mem_wdata [NDUT];
  logic [DATA_W-1:0] mem_dout  [NDUT];

  // model state
  logic [DATA_W-1:0] ref_mem [NDUT][256];
  logic [DATA_W-1:0] exp_if  [NDUT];
  logic [DATA_W-1:0] exp_d   [NDUT];
  bit                last_d  [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [DATA_W-1:0] init_word(input int k, input int a);
    if (a == 16) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ (32'(k) << 16) ^ 32'h13579BDF;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned RL = (g == 0) ? 1 : 3;
      logic [DATA_W-1:0] ram  [256];
      logic [DATA_W-1:0] pipe [RL];

      initial for (int a = 0; a < 256; a++) ram[a] <= init_word(g, a);

      // memory: data for the address seen RL cycles ago
      always @(posedge clk) begin
        pipe[0] <= ram[mem_addr[g]];
        for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
        if (mem_we[g]) ram[mem_waddr[g]] <= mem_wdata[g];
      end
      assign mem_dout[g] = pipe[RL-1];

      mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ_LAT(RL)
      ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req[g]),
        .if_addr      (if_addr[g]),
        .if_ack       (if_ack[g]),
        .if_rdata     (if_rdata[g]),
        .d_req        (d_req[g]),
        .d_we         (d_we[g]),
        .d_addr       (d_addr[g]),
        .d_wdata      (d_wdata[g]),
        .d_ack        (d_ack[g]),
        .d_rdata      (d_rdata[g]),
        .mem_addr     (mem_addr[g]),
        .mem_writeAddr(mem_waddr[g]),
        .mem_writeData(mem_wdata[g]),
        .mem_writeEn  (mem_we[g]),
        .mem_dataOut  (mem_dout[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input int k, input string tag);
    check($sformatf("k%0d %s if_ack", k, tag), 64'(if_ack[k]), 64'(0));
    check($sformatf("k%0d %s d_ack", k, tag), 64'(d_ack[k]), 64'(0));
    check($sformatf("k%0d %s mem_addr", k, tag), 64'(mem_addr[k]), 64'(0));
    check($sformatf("k%0d %s mem_writeAddr", k, tag), 64'(mem_waddr[k]), 64'(0));
    check($sformatf("k%0d %s mem_writeData", k, tag), 64'(mem_wdata[k]), 64'(0));
    check($sformatf("k%0d %s mem_writeEn", k, tag), 64'(mem_we[k]), 64'(0));
    check($sformatf("k%0d %s if_rdata", k, tag), 64'(if_rdata[k]), 64'(exp_if[k]));
    check($sformatf("k%0d %s d_rdata", k, tag), 64'(d_rdata[k]), 64'(exp_d[k]));
  endtask

  // One transaction set: optional fetch read and/or data access raised in an IDLE cycle
  task automatic run_txn(input int k, input bit f, input bit d, input logic [ADDR_W-1:0] fa,
                         input logic [ADDR_W-1:0] da, input bit we, input logic [DATA_W-1:0] wd);
    int lf, ld, sf, sd, tf, td, twe, tend;
    bit d_first;
    logic [ADDR_W-1:0] ema, ewa;
    logic [DATA_W-1:0] ewd;
    lf      = lat_of(k) + 2;
    ld      = (we ? 2 : lat_of(k) + 2);
    d_first = d && (!f || !last_d[k]);
    sf = 0; sd = 0;
    if (f && d) begin
      if (d_first) sf = ld + 1;
      else         sd = lf + 1;
      last_d[k] = !d_first;
    end else if (f || d) begin
      last_d[k] = d;
    end
    tf   = f ? sf + lf : -1;
    td   = d ? sd + ld : -1;
    twe  = (d && we) ? sd + 1 : -1;
    tend = (tf > td) ? tf : td;
    if_req[k] = f; if_addr[k] = fa;
    d_req[k] = d; d_we[k] = we; d_addr[k] = da; d_wdata[k] = wd;
    for (int n = 1; n <= tend; n++) begin
      @(posedge clk); #1;
      ema = '0; ewa = '0; ewd = '0;
      if (f && n > sf && n < tf) ema = fa;
      if (d && n > sd && n < td) ema = da;
      if (n == twe) begin
        ewa = da; ewd = wd;
        ref_mem[k][da] = wd;
      end
      if (n == tf) exp_if[k] = ref_mem[k][fa];
      if (n == td && !we) exp_d[k] = ref_mem[k][da];
      check($sformatf("k%0d n%0d mem_addr", k, n), 64'(mem_addr[k]), 64'(ema));
      check($sformatf("k%0d n%0d mem_writeEn", k, n), 64'(mem_we[k]), 64'(n == twe));
      check($sformatf("k%0d n%0d mem_writeAddr", k, n), 64'(mem_waddr[k]), 64'(ewa));
      check($sformatf("k%0d n%0d mem_writeData", k, n), 64'(mem_wdata[k]), 64'(ewd));
      check($sformatf("k%0d n%0d if_ack", k, n), 64'(if_ack[k]), 64'(n == tf));
      check($sformatf("k%0d n%0d d_ack", k, n), 64'(d_ack[k]), 64'(n == td));
      check($sformatf("k%0d n%0d if_rdata", k, n), 64'(if_rdata[k]), 64'(exp_if[k]));
      check($sformatf("k%0d n%0d d_rdata", k, n), 64'(d_rdata[k]), 64'(exp_d[k]));
      if (n == tf) if_req[k] = 1'b0;
      if (n == td) d_req[k] = 1'b0;
    end
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    @(posedge clk); #1;
    check_quiet(k, "idle");
  endtask

  // Fetch request held high across its ack: a second fetch follows immediately
  task automatic run_b2b(input int k, input logic [ADDR_W-1:0] fa);
    int t1, t2, lat;
    lat = lat_of(k);
    t1 = -1; t2 = -1;
    if_req[k] = 1'b1; if_addr[k] = fa;
    for (int n = 1; n <= 3 * (lat + 3) && t2 < 0; n++) begin
      @(posedge clk); #1;
      if (if_ack[k]) begin
        if (t1 < 0) t1 = n;
        else        t2 = n;
      end
      check($sformatf("k%0d b2b n%0d d_rdata", k, n), 64'(d_rdata[k]), 64'(exp_d[k]));
      check($sformatf("k%0d b2b n%0d d_ack", k, n), 64'(d_ack[k]), 64'(0));
    end
    if_req[k] = 1'b0;
    exp_if[k] = ref_mem[k][fa];
    last_d[k] = 1'b0;
    check($sformatf("k%0d b2b first ack cycle", k), 64'(t1), 64'(lat + 2));
    check($sformatf("k%0d b2b ack spacing", k), 64'(t2 - t1), 64'(lat + 3));
    check($sformatf("k%0d b2b if_rdata", k), 64'(if_rdata[k]), 64'(exp_if[k]));
    @(posedge clk); #1;
    check_quiet(k, "b2b idle");
  endtask

  task automatic model_reset();
    for (int k = 0; k < int'(NDUT); k++) begin
      exp_if[k] = '0; exp_d[k] = '0; last_d[k] = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = '0; d_req = '0; d_we = '0;
    for (int k = 0; k < int'(NDUT); k++) begin
      if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(k, a);
    end
    model_reset();
    #3;
    for (int k = 0; k < int'(NDUT); k++) check_quiet(k, "reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // tie out of reset: fetch first; then plain fetch; then tie goes to data
    run_txn(0, 1, 1, 8'h01, 8'h02, 1'b0, '0);
    run_txn(0, 1, 0, 8'h10, 8'h00, 1'b0, '0);
    check("k0 fetch 0x10 value", 64'(if_rdata[0]), 64'h0000_0000_DEAD_BEEF);
    run_txn(0, 1, 1, 8'h03, 8'h04, 1'b0, '0);
    // write then read back
    run_txn(0, 0, 1, 8'h00, 8'h20, 1'b1, 32'h12345678);
    run_txn(0, 0, 1, 8'h00, 8'h20, 1'b0, '0);
    check("k0 readback 0x20", 64'(d_rdata[0]), 64'h0000_0000_1234_5678);
    run_b2b(0, 8'h05);

    // longer latency instance
    run_txn(1, 1, 0, 8'h10, 8'h00, 1'b0, '0);
    run_txn(1, 0, 1, 8'h00, 8'h07, 1'b1, 32'hCAFEF00D);
    run_txn(1, 1, 1, 8'h07, 8'h08, 1'b0, '0);
    run_b2b(1, 8'h09);

    // reset during ISSUE of a write aborts it with no ack
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h30; d_wdata[0] = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    check("k0 abort writeEn in issue", 64'(mem_we[0]), 64'(1));
    reset = 1'b1;
    #1;
    model_reset();
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    check_quiet(0, "abort");
    check_quiet(1, "abort");
    repeat (3) begin
      @(posedge clk); #1;
      check("k0 abort no d_ack", 64'(d_ack[0]), 64'(0));
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_txn(0, 1, 1, 8'h30, 8'h30, 1'b0, '0);

    // randomized traffic
    for (int k = 0; k < int'(NDUT); k++) begin
      for (int it = 0; it < 150; it++) begin
        if ($urandom_range(0, 19) == 0)
          run_b2b(k, 8'($urandom_range(0, 15)));
        else
          run_txn(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
